image_frame_scheduler: RTL and testbench
========================================

// Module: image_frame_scheduler
// PURPOSE
//   Sequences an image_background generator: issues one-cycle frame requests, tracks frame
//   completion via its out_sending, and steps its operation select (solid/grid) between frames.
//   Enforces an inter-frame gap and a start-timeout watchdog. Sits beside the generator in a
//   source pipeline; drives its out_request_external and operation inputs.
// PARAMETERS
//   FrameGap           16   idle cycles between frame end and next request (0 = back-to-back)
//   FramesPerOperation 4    frames emitted before operation advances (>=1)
//   OperationCount     2    operations cycled, 0..OperationCount-1 (1..4)
//   StartTimeout       64   cycles allowed from request to sending_in high (>=2)
//   FrameCountWidth    16   width of frame_count
// PORTS
//   clock            in   1   system clock
//   reset            in   1   reset; one clock; reset is asynchronous and active-low
//   enable           in   1   free-run: request frames continuously while high
//   start            in   1   single-shot: request one frame (ignored unless IDLE)
//   error_clear      in   1   clears sticky timeout_error
//   sending_in       in   1   generator out_sending
//   request_out      out  1   to generator out_request_external; one-cycle pulse
//   operation        out  2   to generator operation; stable whenever sending_in or busy
//   busy             out  1   high in any state except IDLE
//   frame_count      out  FrameCountWidth  completed frames, wraps to 0 after all-ones
//   timeout_error    out  1   sticky: generator failed to start within StartTimeout
//   frame_cycles     out  24  cycles of last completed frame (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE; request_out=0, operation=0, busy=0,
//     frame_count=0, timeout_error=0, frame_cycles=0, gap/timeout/frame-per-op counters=0.
//   - All outputs registered. States: IDLE, REQUEST, WAIT_START, SENDING, GAP.
//   - IDLE: if (enable|start) && !sending_in && !timeout_error -> REQUEST. sending_in high in
//     IDLE (generator busy from elsewhere / pre-reset frame) blocks request until low.
//   - REQUEST: request_out=1 exactly this cycle (state entered cycle N+1 after trigger at N)
//     -> WAIT_START; timeout counter cleared.
//   - WAIT_START: sending_in=1 -> SENDING. Else counter++; at StartTimeout-1 -> set
//     timeout_error, -> IDLE, frame_count unchanged.
//   - SENDING: on sending_in=0 (frame done): frame_count++ (mod 2^FrameCountWidth);
//     per-op counter++; if it reaches FramesPerOperation: cleared, operation <=
//     (operation==OperationCount-1) ? 0 : operation+1. -> GAP if FrameGap>0 else as GAP exit.
//   - GAP: count FrameGap cycles; on expiry: enable && !sending_in -> REQUEST, else -> IDLE.
//   - operation changes only on the SENDING->GAP/IDLE transition, never mid-frame.
//   - enable dropped mid-frame: frame completes, counted, gap served, then IDLE.
//   - start while busy: ignored (not queued). start and enable both high: one request.
//   - error_clear: clears timeout_error next cycle; if same cycle as timeout, error wins.
//   - timeout_error high blocks new requests until cleared.
//   - Reset mid-frame: immediate IDLE; later sending_in high held off until it drops.
// CONFIGURATION
//   IMAGE_FRAME_SCHEDULER_STATS_EN defined: 24-bit cycle counter cleared on SENDING entry,
//     increments each SENDING cycle, saturates at all-ones; copied to frame_cycles on frame
//     done. Undefined: counter absent, frame_cycles tied to 0.
// TESTING
//   1 start pulse, generator 4x4 (16 sending cycles) -> request_out 1 cycle, frame_count=1,
//     busy low FrameGap+1 cycles after sending_in falls; STATS_EN: frame_cycles=16.
//   2 enable held, FramesPerOperation=4, OperationCount=2 -> operation 0 for frames 1-4,
//     1 for 5-8, 0 for 9; request spacing = frame length + FrameGap + 2 cycles.
//   3 request with sending_in held low 64 cycles -> timeout_error=1, IDLE, frame_count
//     unchanged; enable ignored until error_clear, then next request issued.
//   4 enable dropped mid-frame 3 -> frame_count=3, no further request_out, busy falls after gap.
//   5 reset low mid-SENDING, sending_in stays high 10 cycles after release with enable=1 ->
//     all outputs 0 immediately; first request_out only after sending_in falls.
//   6 frame_count preset near wrap (FrameCountWidth=4, 16 frames) -> frame_count 15 then 0.

Source files
------------

// File: rtl/image_frame_scheduler.sv
// Frame sequencer for an image_background generator: one-cycle requests, inter-frame gap,
// start-timeout watchdog, operation stepping. Optional IMAGE_FRAME_SCHEDULER_STATS_EN adds frame_cycles.
module image_frame_scheduler #(
  parameter int FrameGap           = 16,
  parameter int FramesPerOperation = 4,
  parameter int OperationCount     = 2,
  parameter int StartTimeout       = 64,
  parameter int FrameCountWidth    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       start,
  input  logic                       error_clear,
  input  logic                       sending_in,
  output logic                       request_out,
  output logic [1:0]                 operation,
  output logic                       busy,
  output logic [FrameCountWidth-1:0] frame_count,
  output logic                       timeout_error,
  output logic [23:0]                frame_cycles
);

  localparam int GapW = (FrameGap > 1) ? $clog2(FrameGap) : 1;
  localparam int ToW  = $clog2(StartTimeout);
  localparam int OpfW = (FramesPerOperation > 1) ? $clog2(FramesPerOperation) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_WAIT_START, S_SENDING, S_GAP
  } state_e;

  state_e                     state_q;
  logic [GapW-1:0]            gap_q;
  logic [ToW-1:0]             timeout_q;
  logic [OpfW-1:0]            per_op_q;
  logic                       request_q;
  logic                       busy_q;
  logic                       error_q;
  logic [1:0]                 op_q;
  logic [FrameCountWidth-1:0] count_q;

  logic       trigger_d;
  logic       relaunch_d;
  logic       op_wrap_d;
  logic       gap_done_d;
  logic       timeout_hit_d;
  logic [1:0] op_next_d;

  // A generator still sending (from elsewhere or from before reset) holds off new requests.
  assign trigger_d     = (enable | start) & ~sending_in & ~error_q;
  assign relaunch_d    = enable & ~sending_in;
  assign op_wrap_d     = (per_op_q == OpfW'(FramesPerOperation - 1));
  assign gap_done_d    = (gap_q == GapW'(FrameGap - 1));
  assign timeout_hit_d = (timeout_q == ToW'(StartTimeout - 1));
  assign op_next_d     = (op_q == 2'(OperationCount - 1)) ? 2'd0 : op_q + 2'd1;

  // Frame sequencing FSM with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      timeout_q <= '0;
      per_op_q  <= '0;
      request_q <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      op_q      <= 2'd0;
      count_q   <= '0;
    end else begin
      request_q <= 1'b0;
      if (error_clear) error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trigger_d) begin
            state_q   <= S_REQUEST;
            request_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_REQUEST: begin
          state_q   <= S_WAIT_START;
          timeout_q <= '0;
        end
        S_WAIT_START: begin
          if (sending_in) begin
            state_q <= S_SENDING;
          end else if (timeout_hit_d) begin
            error_q <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            timeout_q <= timeout_q + 1'b1;
          end
        end
        S_SENDING: begin
          if (!sending_in) begin
            count_q <= count_q + 1'b1;
            gap_q   <= '0;
            // Operation only ever moves here, between frames.
            if (op_wrap_d) begin
              per_op_q <= '0;
              op_q     <= op_next_d;
            end else begin
              per_op_q <= per_op_q + 1'b1;
            end
            if (FrameGap > 0) begin
              state_q <= S_GAP;
            end else if (enable) begin
              state_q   <= S_REQUEST;
              request_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_done_d) begin
            if (relaunch_d) begin
              state_q   <= S_REQUEST;
              request_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMAGE_FRAME_SCHEDULER_STATS_EN
  logic [23:0] stat_q;
  logic [23:0] cycles_q;

  // The entry cycle is itself a sending cycle, so the counter restarts at one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_q   <= 24'd0;
      cycles_q <= 24'd0;
    end else begin
      if (state_q == S_WAIT_START && sending_in) begin
        stat_q <= 24'd1;
      end else if (state_q == S_SENDING && sending_in && stat_q != 24'hFF_FFFF) begin
        stat_q <= stat_q + 24'd1;
      end
      if (state_q == S_SENDING && !sending_in) begin
        cycles_q <= stat_q;
      end
    end
  end

  assign frame_cycles = cycles_q;
`else
  assign frame_cycles = 24'd0;
`endif

  assign request_out   = request_q;
  assign operation     = op_q;
  assign busy          = busy_q;
  assign frame_count   = count_q;
  assign timeout_error = error_q;

endmodule

// File: tb/tb_image_frame_scheduler.sv
// Directed self-checking bench for image_frame_scheduler; a second instance with a
// 4-bit frame counter checks wrap-around.
module tb_image_frame_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic start = 1'b0;
  logic error_clear = 1'b0;
  logic sending_in = 1'b0;

  logic        request_out, busy, timeout_error;
  logic [1:0]  operation;
  logic [15:0] frame_count;
  logic [23:0] frame_cycles;

  logic        w_request_out, w_busy, w_timeout_error;
  logic [1:0]  w_operation;
  logic [3:0]  w_frame_count;
  logic [23:0] w_frame_cycles;

  int total = 0;
  int bad = 0;
  int cyc = 0;

`ifdef IMAGE_FRAME_SCHEDULER_STATS_EN
  localparam logic [23:0] Cyc16 = 24'd16;
  localparam logic [23:0] Cyc4  = 24'd4;
`else
  localparam logic [23:0] Cyc16 = 24'd0;
  localparam logic [23:0] Cyc4  = 24'd0;
`endif

  image_frame_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .error_clear(error_clear), .sending_in(sending_in),
    .request_out(request_out), .operation(operation), .busy(busy),
    .frame_count(frame_count), .timeout_error(timeout_error), .frame_cycles(frame_cycles)
  );

  image_frame_scheduler #(.FrameCountWidth(4)) dut_w (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .error_clear(error_clear), .sending_in(sending_in),
    .request_out(w_request_out), .operation(w_operation), .busy(w_busy),
    .frame_count(w_frame_count), .timeout_error(w_timeout_error), .frame_cycles(w_frame_cycles)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; start = 1'b0; error_clear = 1'b0; sending_in = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Acts as the generator: answers a request with len sending cycles, one cycle later.
  task automatic run_frame(input int len, input int drop_at, output int req_at);
    int n;
    n = 0;
    while (!request_out && n < 200) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (request_out !== 1'b1) begin
      $display("FAIL req_wait: request_out=%b required 1", request_out);
      bad++;
      req_at = -1;
    end else begin
      req_at = cyc;
      @(negedge clock);
      total++;
      if (request_out !== 1'b0) begin
        $display("FAIL req_pulse: request_out=%b required 0", request_out);
        bad++;
      end
      sending_in = 1'b1;
      for (int k = 0; k < len; k++) begin
        if (k == drop_at) enable = 1'b0;
        @(negedge clock);
      end
      sending_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if ({request_out, operation, busy, frame_count, timeout_error, frame_cycles} !== 46'd0) begin
      $display("FAIL reset_outs: req=%b op=%0d busy=%b cnt=%0d err=%b cyc=%0d required all 0",
               request_out, operation, busy, frame_count, timeout_error, frame_cycles);
      bad++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_start();
    int t;
    do_reset();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    total++;
    if (request_out !== 1'b1) begin
      $display("FAIL start_latency: request_out=%b required 1", request_out); bad++;
    end
    run_frame(16, -1, t);
    repeat (16) @(negedge clock);
    total++;
    if (busy !== 1'b1) begin $display("FAIL busy_in_gap: busy=%b required 1", busy); bad++; end
    @(negedge clock);
    total++;
    if (busy !== 1'b0) begin $display("FAIL busy_after_gap: busy=%b required 0", busy); bad++; end
    total++;
    if (frame_count !== 16'd1) begin
      $display("FAIL single_count: frame_count=%0d required 1", frame_count); bad++;
    end
    total++;
    if (frame_cycles !== Cyc16) begin
      $display("FAIL single_cycles: frame_cycles=%0d required %0d", frame_cycles, Cyc16); bad++;
    end
  endtask

  task automatic test_enable_ops();
    int t, prev;
    logic [1:0] exp_op;
    do_reset();
    enable = 1'b1;
    prev = 0;
    for (int i = 1; i <= 9; i++) begin
      run_frame(4, -1, t);
      exp_op = 2'(((i - 1) / 4) % 2);
      total++;
      if (operation !== exp_op) begin
        $display("FAIL op_frame%0d: operation=%0d required %0d", i, operation, exp_op); bad++;
      end
      if (i > 1) begin
        total++;
        if (t - prev != 22) begin
          $display("FAIL spacing%0d: spacing=%0d required 22", i, t - prev); bad++;
        end
      end
      prev = t;
    end
    enable = 1'b0;
    @(negedge clock);
    total++;
    if (frame_count !== 16'd9 || operation !== 2'd0) begin
      $display("FAIL ops_end: frame_count=%0d op=%0d required 9 op 0", frame_count, operation); bad++;
    end
    total++;
    if (frame_cycles !== Cyc4) begin
      $display("FAIL ops_cycles: frame_cycles=%0d required %0d", frame_cycles, Cyc4); bad++;
    end
    repeat (20) @(negedge clock);
  endtask

  task automatic test_timeout();
    int n, t;
    logic seen;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (!request_out && n < 10) begin @(negedge clock); n++; end
    repeat (64) @(negedge clock);
    total++;
    if (timeout_error !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL timeout_early: err=%b busy=%b required 0 1", timeout_error, busy); bad++;
    end
    @(negedge clock);
    total++;
    if (timeout_error !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd0) begin
      $display("FAIL timeout_hit: err=%b busy=%b cnt=%0d required 1 0 0",
               timeout_error, busy, frame_count); bad++;
    end
    seen = 1'b0;
    repeat (10) begin @(negedge clock); seen = seen | request_out | busy; end
    total++;
    if (seen !== 1'b0) begin
      $display("FAIL timeout_blocks: request/busy seen=%b required 0", seen); bad++;
    end
    error_clear = 1'b1;
    @(negedge clock);
    error_clear = 1'b0;
    total++;
    if (timeout_error !== 1'b0 || request_out !== 1'b0) begin
      $display("FAIL clear: err=%b req=%b required 0 0", timeout_error, request_out); bad++;
    end
    @(negedge clock);
    total++;
    if (request_out !== 1'b1) begin
      $display("FAIL clear_req: request_out=%b required 1", request_out); bad++;
    end
    run_frame(4, -1, t);
    enable = 1'b0;
    repeat (20) @(negedge clock);
  endtask

  task automatic test_drop_enable();
    int t;
    logic seen;
    do_reset();
    enable = 1'b1;
    run_frame(4, -1, t);
    run_frame(4, -1, t);
    run_frame(4, 2, t);
    seen = 1'b0;
    repeat (16) begin @(negedge clock); seen = seen | request_out; end
    total++;
    if (busy !== 1'b1) begin $display("FAIL drop_busy_gap: busy=%b required 1", busy); bad++; end
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || frame_count !== 16'd3) begin
      $display("FAIL drop_end: busy=%b cnt=%0d required 0 3", busy, frame_count); bad++;
    end
    repeat (20) begin @(negedge clock); seen = seen | request_out; end
    total++;
    if (seen !== 1'b0) begin $display("FAIL drop_no_req: request seen=%b required 0", seen); bad++; end
  endtask

  task automatic test_reset_mid();
    int n, t;
    logic seen;
    do_reset();
    enable = 1'b1;
    run_frame(4, -1, t);
    n = 0;
    while (!request_out && n < 40) begin @(negedge clock); n++; end
    @(negedge clock);
    sending_in = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if ({request_out, operation, busy, frame_count, timeout_error, frame_cycles} !== 46'd0) begin
      $display("FAIL midreset_outs: req=%b op=%0d busy=%b cnt=%0d err=%b cyc=%0d required all 0",
               request_out, operation, busy, frame_count, timeout_error, frame_cycles); bad++;
    end
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clock); seen = seen | request_out | busy; end
    total++;
    if (seen !== 1'b0) begin
      $display("FAIL midreset_holdoff: request/busy seen=%b required 0", seen); bad++;
    end
    sending_in = 1'b0;
    @(negedge clock);
    total++;
    if (request_out !== 1'b1) begin
      $display("FAIL midreset_req: request_out=%b required 1", request_out); bad++;
    end
    run_frame(4, -1, t);
    enable = 1'b0;
    repeat (20) @(negedge clock);
  endtask

  task automatic test_wrap();
    int t;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 15; i++) run_frame(2, -1, t);
    @(negedge clock);
    total++;
    if (w_frame_count !== 4'd15) begin
      $display("FAIL wrap_15: frame_count=%0d required 15", w_frame_count); bad++;
    end
    run_frame(2, -1, t);
    enable = 1'b0;
    @(negedge clock);
    total++;
    if (w_frame_count !== 4'd0 || frame_count !== 16'd16) begin
      $display("FAIL wrap_0: narrow=%0d wide=%0d required 0 16", w_frame_count, frame_count); bad++;
    end
    repeat (20) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_start();
    test_enable_ops();
    test_timeout();
    test_drop_enable();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
